// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one external memory port between the CPU and the
//               program loader. It grants one requester at a time from IDLE,
//               runs the req/ack transaction toward memory in BUSY, and
//               produces a one-cycle done pulse with read data in RESP.
//               A BUSY watchdog aborts unanswered transactions.
// Ports       :
//   clk, rst                          clock, synchronous active-high reset
//   cpu_req/we/addr/wdata (in)        CPU request, held until cpu_done
//   cpu_rdata, cpu_done, cpu_stall    CPU response and stall indication
//   ld_req/we/addr/wdata (in)         loader request, held until ld_done
//   ld_rdata, ld_done                 loader response
//   ld_lock (in)                      blocks CPU grants (programming mode)
//   mem_req/we/addr/wdata (out)       registered memory request
//   mem_rdata, mem_ack (in)           memory response
//   timeout_err (out)                 sticky abort flag, cleared by rst
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_done,
    output logic          cpu_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic [7:0]    ld_rdata,
    output logic          ld_done,
    input  logic          ld_lock,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic       OWN_CPU   = 1'b0;
    localparam logic       OWN_LD    = 1'b1;
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_owner;
    logic       r_last_owner;
    logic [7:0] r_cnt;
    logic [7:0] r_resp;

    logic       w_cpu_elig;
    logic       w_grant;
    logic       w_grant_owner;
    logic       w_limit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Grant selection and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = OWN_CPU;
        w_cpu_elig    = cpu_req & ~ld_lock;
        // r_cnt counts completed BUSY cycles, so +1 is the current cycle
        // number; the abort fires on BUSY cycle TIMEOUT.
        w_limit       = ((r_cnt + 8'd1) == C_TIMEOUT);

        case (r_state)
            IDLE: begin
                if (w_cpu_elig && ld_req) begin
                    w_grant       = 1'b1;
                    // Tie: whoever was not served last wins.
                    w_grant_owner = (r_last_owner == OWN_LD) ? OWN_CPU : OWN_LD;
                end else if (w_cpu_elig) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_CPU;
                end else if (ld_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = OWN_LD;
                end
                if (w_grant) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || w_limit) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: memory request registers, watchdog, response register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_CPU;
            r_last_owner <= OWN_LD;
            r_cnt        <= 8'd0;
            r_resp       <= 8'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'd0;
            timeout_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_grant_owner;
                        r_last_owner <= w_grant_owner;
                        r_cnt        <= 8'd0;
                        mem_req      <= 1'b1;
                        if (w_grant_owner == OWN_LD) begin
                            mem_we    <= ld_we;
                            mem_addr  <= ld_addr;
                            mem_wdata <= ld_wdata;
                        end else begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Ack has priority over the watchdog on the same cycle.
                    if (mem_ack) begin
                        r_resp  <= mem_rdata;
                        mem_req <= 1'b0;
                    end else if (w_limit) begin
                        r_resp      <= 8'hFF;
                        mem_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Responses: done is a decode of the RESP state and the owner.
    // ------------------------------------------------------------------
    assign cpu_done  = (r_state == RESP) && (r_owner == OWN_CPU);
    assign ld_done   = (r_state == RESP) && (r_owner == OWN_LD);
    assign cpu_rdata = r_resp;
    assign ld_rdata  = r_resp;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Instance a uses
//               TIMEOUT=4, instance b uses TIMEOUT=3; both share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
    logic [15:0] ld_addr = 16'h0;
    logic [7:0]  ld_wdata = 8'h0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        mem_ack = 1'b0;

    logic [7:0]  cpu_rdata, ld_rdata, mem_wdata;
    logic        cpu_done, cpu_stall, ld_done, mem_req, mem_we, timeout_err;
    logic [15:0] mem_addr;

    logic [7:0]  b_cpu_rdata, b_ld_rdata, b_mem_wdata;
    logic        b_cpu_done, b_cpu_stall, b_ld_done, b_mem_req, b_mem_we, b_timeout_err;
    logic [15:0] b_mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(16), .TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_done(ld_done), .ld_lock(ld_lock),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    mem_arbiter #(.AW(16), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(b_ld_rdata), .ld_done(b_ld_done), .ld_lock(ld_lock),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(b_timeout_err)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first cycle after reset with rst low.
    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset mem_req got=%b exp=0", mem_req); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset mem_we got=%b exp=0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset mem_addr got=%h exp=0000", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h0) begin n_fail++; $display("FAIL reset mem_wdata got=%h exp=00", mem_wdata); end
        n_checks++; if ({cpu_done, ld_done} !== 2'b00) begin n_fail++; $display("FAIL reset done got=%b%b exp=00", cpu_done, ld_done); end
        n_checks++; if ({cpu_rdata, ld_rdata} !== 16'h0) begin n_fail++; $display("FAIL reset rdata got=%h/%h exp=00/00", cpu_rdata, ld_rdata); end
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_cpu_read();
        // cycle 0
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123;
        #1;
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rd c0 cpu_stall got=%b exp=1", cpu_stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rd c0 mem_req got=%b exp=0", mem_req); end
        // cycle 1
        tick(); #1;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rd c1 mem_req got=%b exp=1", mem_req); end
        n_checks++; if (mem_addr !== 16'h0123 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd c1 addr/we got=%h/%b exp=0123/0", mem_addr, mem_we); end
        n_checks++; if (cpu_stall !== 1'b1 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL rd c1 stall/done got=%b/%b exp=1/0", cpu_stall, cpu_done); end
        // cycle 2: ack
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h5A;
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0123 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rd c2 req/addr/we got=%b/%h/%b exp=1/0123/0", mem_req, mem_addr, mem_we); end
        n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rd c2 cpu_stall got=%b exp=1", cpu_stall); end
        // cycle 3: done
        tick();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        #1;
        n_checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd c3 done/rdata got=%b/%h exp=1/5a", cpu_done, cpu_rdata); end
        n_checks++; if (mem_req !== 1'b0 || ld_done !== 1'b0) begin n_fail++; $display("FAIL rd c3 mem_req/ld_done got=%b/%b exp=0/0", mem_req, ld_done); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL rd c3 cpu_stall got=%b exp=0", cpu_stall); end
        // cycle 4
        tick();
        cpu_req = 1'b0;
        #1;
        n_checks++; if (cpu_done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rd c4 done/terr got=%b/%b exp=0/0", cpu_done, timeout_err); end
    endtask

    task automatic test_round_robin();
        logic exp_ld;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1111;
        ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 16'h2222; ld_wdata = 8'h44;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_ld = (k == 1);   // CPU, loader, CPU
            tick();
            mem_ack = 1'b1; mem_rdata = 8'(8'h10 + k);
            #1;
            n_checks++; if (mem_addr !== (exp_ld ? 16'h2222 : 16'h1111) || mem_we !== exp_ld) begin n_fail++; $display("FAIL rr grant%0d addr/we got=%h/%b exp_ld=%b", k, mem_addr, mem_we, exp_ld); end
            tick();
            mem_ack = 1'b0;
            #1;
            n_checks++; if (cpu_done !== !exp_ld || ld_done !== exp_ld) begin n_fail++; $display("FAIL rr done%0d cpu/ld got=%b/%b exp_ld=%b", k, cpu_done, ld_done, exp_ld); end
            n_checks++; if (cpu_rdata !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL rr rdata%0d got=%h exp=%h", k, cpu_rdata, 8'(8'h10 + k)); end
            tick();
        end
        cpu_req = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        #1;
    endtask

    task automatic test_lock();
        tick();
        ld_lock = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3333;
        ld_req  = 1'b1; ld_we  = 1'b1; ld_addr  = 16'h0010; ld_wdata = 8'hC3;
        #1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            mem_ack = mem_req;   // memory answers on the first BUSY cycle
            #1;
            n_checks++; if (mem_req !== (i % 3 == 1)) begin n_fail++; $display("FAIL lock c%0d mem_req got=%b exp=%b", i, mem_req, (i % 3 == 1)); end
            n_checks++; if (ld_done !== (i % 3 == 2) || cpu_done !== 1'b0) begin n_fail++; $display("FAIL lock c%0d ld/cpu done got=%b/%b", i, ld_done, cpu_done); end
            n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL lock c%0d cpu_stall got=%b exp=1", i, cpu_stall); end
            if (mem_req) begin
                n_checks++; if (mem_addr !== 16'h0010 || mem_we !== 1'b1 || mem_wdata !== 8'hC3) begin n_fail++; $display("FAIL lock c%0d addr/we/wd got=%h/%b/%h exp=0010/1/c3", i, mem_addr, mem_we, mem_wdata); end
            end
        end
        mem_ack = 1'b0;
        ld_req = 1'b0; cpu_req = 1'b0; ld_lock = 1'b0; ld_we = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0444;
        mem_ack = 1'b0; mem_rdata = 8'h12;
        #1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_checks++; if (mem_req !== 1'b1 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL to c%0d req/done got=%b/%b exp=1/0", i, mem_req, cpu_done); end
        end
        tick();
        n_checks++; if (mem_req !== 1'b0 || cpu_done !== 1'b1 || cpu_rdata !== 8'hFF) begin n_fail++; $display("FAIL to c5 req/done/rdata got=%b/%b/%h exp=0/1/ff", mem_req, cpu_done, cpu_rdata); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to c5 timeout_err got=%b exp=1", timeout_err); end
        cpu_req = 1'b0;
        tick();
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0888;
        #1;
        n_checks++; if (timeout_err !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL to c6 terr/req got=%b/%b exp=1/0", timeout_err, mem_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 8'h77;
        #1;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (ld_done !== 1'b1 || ld_rdata !== 8'h77 || cpu_done !== 1'b0) begin n_fail++; $display("FAIL to ok ld_done/rdata/cpu_done got=%b/%h/%b exp=1/77/0", ld_done, ld_rdata, cpu_done); end
        n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to sticky timeout_err got=%b exp=1", timeout_err); end
        ld_req = 1'b0;
        tick();
        do_reset();
        n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to clear timeout_err got=%b exp=0", timeout_err); end
    endtask

    task automatic test_reset_mid_busy();
        tick();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 16'h0055; ld_wdata = 8'hAA;
        #1;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'hAA) begin n_fail++; $display("FAIL rmb busy req/we/wd got=%b/%b/%h exp=1/1/aa", mem_req, mem_we, mem_wdata); end
        rst = 1'b1;
        tick();
        n_checks++; if (mem_req !== 1'b0 || ld_done !== 1'b0) begin n_fail++; $display("FAIL rmb after rst req/ld_done got=%b/%b exp=0/0", mem_req, ld_done); end
        rst = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        tick();
        n_checks++; if (mem_req !== 1'b0 || ld_done !== 1'b0) begin n_fail++; $display("FAIL rmb idle req/ld_done got=%b/%b exp=0/0", mem_req, ld_done); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0666;
        #1;
        tick();
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0666) begin n_fail++; $display("FAIL rmb cpu grant req/addr got=%b/%h exp=1/0666", mem_req, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (cpu_done !== 1'b1 || cpu_rdata !== 8'h3C || ld_done !== 1'b0) begin n_fail++; $display("FAIL rmb cpu done/rdata/ld_done got=%b/%h/%b exp=1/3c/0", cpu_done, cpu_rdata, ld_done); end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_limit();
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777;
        mem_ack = 1'b0;
        #1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            mem_ack = (i == 3); mem_rdata = 8'h99;
            #1;
            n_checks++; if (b_mem_req !== 1'b1) begin n_fail++; $display("FAIL lim c%0d mem_req got=%b exp=1", i, b_mem_req); end
        end
        tick();
        mem_ack = 1'b0;
        #1;
        n_checks++; if (b_cpu_done !== 1'b1 || b_cpu_rdata !== 8'h99) begin n_fail++; $display("FAIL lim done/rdata got=%b/%h exp=1/99", b_cpu_done, b_cpu_rdata); end
        n_checks++; if (b_timeout_err !== 1'b0 || b_mem_req !== 1'b0) begin n_fail++; $display("FAIL lim terr/req got=%b/%b exp=0/0", b_timeout_err, b_mem_req); end
        cpu_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_busy();
        test_ack_at_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single external memory port between the CPU fetch/data path and the program loader. Grants one requester at a time through a fixed request/done handshake, runs the multi-cycle req/ack transaction toward memory, and returns read data. It drives `cpu_stall` so the control unit can freeze its step counter while a CPU access is outstanding. It sits between the CPU core/loader and the top-level memory pins.

## Interface
Parameters:
- `AW`, default 16: address width.
- `TIMEOUT`, default 255: maximum BUSY cycles waiting for `mem_ack` before abort; range 1..255.

Ports:
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request; held until `cpu_done`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: read data; valid while `cpu_done` = 1.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_stall` out 1: equals `cpu_req & ~cpu_done` (combinational).
- `ld_req`, `ld_we`, `ld_addr[AW]`, `ld_wdata[8]` in: loader request, same rules as the CPU request.
- `ld_rdata` out 8, `ld_done` out 1: loader response, same rules as the CPU response.
- `ld_lock` in 1: while 1, the CPU is never granted (programming mode).
- `mem_req` out 1: memory request; registered.
- `mem_we` out 1, `mem_addr` out AW, `mem_wdata` out 8: registered; stable while `mem_req` = 1.
- `mem_rdata` in 8: memory read data; sampled on the `mem_ack` cycle.
- `mem_ack` in 1: memory completion; one cycle or longer.
- `timeout_err` out 1: sticky; set on abort, cleared only by `rst`.

## Operation
- States:
  - IDLE: grant is decided here.
  - BUSY: transaction in flight toward memory.
  - RESP: one-cycle response.
- IDLE, requester selection:
  - Eligible requesters are `ld_req`, and `cpu_req & ~ld_lock`.
  - One eligible requester: grant it.
  - Both eligible: round-robin on the `last_owner` bit. The winner is the requester that was not granted last. `last_owner` resets to LD, so the CPU wins the first tie after reset.
  - None eligible: stay in IDLE.
- On grant:
  - Latch owner, we, addr and wdata into `mem_*`.
  - Set `mem_req` = 1.
  - Update `last_owner`.
  - Clear the timeout counter.
  - Go to BUSY.
- BUSY:
  - `mem_req` and `mem_*` are held constant. The counter increments each cycle.
  - If `mem_ack` = 1: capture `mem_rdata` into the response register (reads and writes alike), clear `mem_req`, go to RESP.
  - Else, if the counter reaches `TIMEOUT`: clear `mem_req`, set `timeout_err`, load the response register with 8'hFF, go to RESP.
  - If `mem_ack` arrives on the same cycle the counter reaches `TIMEOUT`, the ack wins and no error is raised.
- RESP:
  - The owner's `done` = 1 for exactly this cycle.
  - Both `rdata` outputs show the response register. The non-owner's `done` stays 0.
  - Next state is IDLE.
- `mem_ack` outside BUSY is ignored. An ack still high on entry to the next BUSY counts as a new ack; memory must drop ack once `mem_req` falls.
- Requesters must hold req and all request fields stable until `done`. The arbiter latches them at grant, so later changes have no effect on the transaction in flight.
- A requester that keeps req high after `done` is re-sampled in the following IDLE cycle as a new request.
- `ld_lock` rising while a CPU access is in BUSY does not abort it; the lock takes effect at the next IDLE.
- Reset values:
  - State IDLE, `last_owner` = LD.
  - `mem_req`, `mem_we`, `cpu_done`, `ld_done`, `timeout_err` = 0.
  - `mem_addr`, `mem_wdata`, both `rdata` = 0.
- Reset mid-BUSY abandons the transaction, with `mem_req` = 0 after the reset edge. No `done` pulse is produced for the abandoned access.

## Timing
- Cycle 0: req high in IDLE.
- Cycle 1: BUSY, `mem_req` = 1.
- Ack on cycle k (k ≥ 1): `done` pulses on cycle k+1 and `mem_req` = 0 on cycle k+1.
- Cycle k+2: IDLE, a new grant is possible.
- Minimum access is 3 cycles (ack on the first BUSY cycle). Back-to-back throughput is one access per 3 cycles.
- Timeout abort: `mem_req` is high for exactly `TIMEOUT` cycles (1..`TIMEOUT`). `done` pulses on cycle `TIMEOUT`+1 with `rdata` = 8'hFF.
- `cpu_stall` is high from the first cycle `cpu_req` is high up to, but not including, the `cpu_done` cycle.

## Test plan
- CPU read at addr 16'h0123 with memory returning 8'h5A, ack on cycle 2 -> `mem_addr` = 16'h0123 and `mem_we` = 0 during cycles 1-2; `cpu_done` and `cpu_rdata` = 8'h5A on cycle 3; `cpu_stall` = 1 on cycles 0-2.
- CPU and loader both request on the first cycle after reset, both held -> CPU served first, then loader, then CPU; grants alternate; each `done` goes to the correct side only.
- `ld_lock` = 1 with `cpu_req` high for 20 cycles and loader writes of 8'hC3 to 16'h0010 -> only loader grants occur; `mem_we` = 1 and `mem_wdata` = 8'hC3; `cpu_stall` stays 1 throughout.
- `TIMEOUT` = 4, memory never acks -> `mem_req` high for exactly 4 cycles; `done` with `rdata` = 8'hFF; `timeout_err` = 1 and stays 1 through later successful accesses until `rst`.
- `rst` asserted during BUSY of a loader write -> next cycle `mem_req` = 0, no `ld_done`, state IDLE; a following CPU request completes normally.
- Ack on the same cycle as the timeout limit (`TIMEOUT` = 3, ack on BUSY cycle 3) -> normal response with `mem_rdata`; `timeout_err` stays 0.
